// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder
//   Adds two WIDTH-bit operands CHUNK bits per clock, least-significant chunk
//   first, with one carry register linking the chunks. Handshake: start is
//   accepted only while idle; busy covers the NCHUNK add cycles; done pulses
//   for one cycle when sum/carryout/overflow are valid.
//   WIDTH must be an integer multiple of CHUNK.
//
// Optional feature macro: ADDER_SUB_EN
//   When defined, adds input 'sub'. With sub=1 the block computes a + ~b + 1
//   and carryin is ignored.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   operation request, sampled only while busy=0
//   a, b      in   WIDTH-bit operands, latched at the accepting edge
//   carryin   in   carry into bit 0, latched at the accepting edge
//   sub       in   (ADDER_SUB_EN only) subtract select, latched with a/b
//   busy      out  high while chunks are being processed
//   done      out  one-cycle result-valid pulse
//   sum       out  WIDTH-bit registered result
//   carryout  out  carry out of bit WIDTH-1
//   overflow  out  signed overflow (carry into MSB xor carryout)
module multicycle_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  // Operand B and initial carry as seen by the datapath (inverted B for subtract)
  logic [WIDTH-1:0] b_in_c;
  logic             cin_c;

  always_comb begin
    b_in_c = b;
    cin_c  = carryin;
`ifdef ADDER_SUB_EN
    if (sub) begin
      b_in_c = ~b;
      cin_c  = 1'b1;
    end
`endif
  end

  // Current chunk slice and its CHUNK+1 bit sum
  logic [31:0]      shamt_c;
  logic [WIDTH-1:0] a_sh_c;
  logic [WIDTH-1:0] b_sh_c;
  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK:0]   chunk_sum_c;
  logic [WIDTH-1:0] slot_mask_c;
  logic [WIDTH-1:0] slot_val_c;
  logic             last_c;

  always_comb begin
    shamt_c     = 32'(cnt) * CHUNK;
    a_sh_c      = a_q >> shamt_c;
    b_sh_c      = b_q >> shamt_c;
    a_chunk_c   = a_sh_c[CHUNK-1:0];
    b_chunk_c   = b_sh_c[CHUNK-1:0];
    chunk_sum_c = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + {{CHUNK{1'b0}}, carry_q};
    slot_mask_c = WIDTH'({CHUNK{1'b1}}) << shamt_c;
    slot_val_c  = WIDTH'(chunk_sum_c[CHUNK-1:0]) << shamt_c;
    last_c      = (cnt == CW'(NCHUNK - 1));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_in_c;
            carry_q <= cin_c;
            sum     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= (sum & ~slot_mask_c) | slot_val_c;
          carry_q <= chunk_sum_c[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last_c) begin
            // Carry into the MSB is recovered from the MSB sum bit and its inputs
            carryout <= chunk_sum_c[CHUNK];
            overflow <= a_chunk_c[CHUNK-1] ^ b_chunk_c[CHUNK-1]
                      ^ chunk_sum_c[CHUNK-1] ^ chunk_sum_c[CHUNK];
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
module tb_multicycle_chunk_adder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             sub_s;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  // Expected {overflow, carryout, sum}
  logic [WIDTH+1:0] exp_q[$];

  multicycle_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
`ifdef ADDER_SUB_EN
    .sub      (sub_s),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: plain wide arithmetic, signed overflow from operand/result signs
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                             input logic icin, input logic isub);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = isub ? ~ib : ib;
    cc   = isub ? 1'b1 : icin;
    full = {1'b0, ia} + {1'b0, bb} + (WIDTH+1)'(cc);
    ovf  = (ia[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ia[WIDTH-1]);
    return {ovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Scoreboard monitor: pops one expectation per done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
        check("carryout", 64'(carryout), 64'(e[WIDTH]));
        check("overflow", 64'(overflow), 64'(e[WIDTH+1]));
        check("busy_at_done", 64'(busy), 64'(0));
      end
      if (prev_done) check("done_pulse_width", 64'(1), 64'(0));
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Issue one operation at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic icin,
                       input logic isub, input bit expect_result);
    wait_idle();
    a = ia; b = ib; carryin = icin; sub_s = isub; start = 1'b1;
    if (expect_result) exp_q.push_back(model(ia, ib, icin, isub));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done_edge();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; carryin = 1'b0; sub_s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(carryout), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic op with latency: busy for 8 cycles, done on the 9th negedge
    issue(32'h5, 32'h3, 1'b0, 1'b0, 1'b1);
    check("lat_busy1", 64'(busy), 64'(1));
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      check("lat_busy", 64'(busy), 64'(1));
      check("lat_nodone", 64'(done), 64'(0));
    end
    @(negedge clk);
    check("lat_done", 64'(done), 64'(1));
    repeat (4) @(negedge clk);
    check("hold_sum", 64'(sum), 64'(32'h8));
    check("hold_done_low", 64'(done), 64'(0));

    // Full ripple and signed overflow corners
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    issue(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1);

    // Disturb inputs and pulse start while busy; back-to-back start in done cycle
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      a = $urandom; b = $urandom; carryin = 1'($urandom); start = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done_edge();
    a = 32'h1; b = 32'h2; carryin = 1'b0; sub_s = 1'b0; start = 1'b1;
    exp_q.push_back(model(32'h1, 32'h2, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_done_drop", 64'(done), 64'(0));
    check("b2b_sum_clear", 64'(sum[WIDTH-1:CHUNK]), 64'(0));
    wait_idle();

    // Reset in the 4th RUN cycle aborts with no done
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_cout", 64'(carryout), 64'(0));
    repeat (10) @(negedge clk);
    check("abort_idle", 64'(busy), 64'(0));
    issue(32'h10, 32'h20, 1'b0, 1'b0, 1'b1);

`ifdef ADDER_SUB_EN
    issue(32'h5, 32'h7, 1'b1, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
`endif

    // Randomized operations, sometimes back-to-back in the done cycle
    for (int k = 0; k < 40; k++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rs;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      rs = 1'b0;
`ifdef ADDER_SUB_EN
      rs = 1'($urandom);
`endif
      if ($urandom_range(0, 1) == 1) wait_done_edge();
      issue(ra, rb, 1'($urandom), rs, 1'b1);
    end

    // Drain scoreboard
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
